// File: rtl/tap_read_interconnect.sv
// Read-side TAP interconnect: routes one outstanding read to the DMI or STB sources and
// holds the returned word (or a timeout abort) for the UART TAP.
//
// state | meaning
// IDLE  | ready for a TAP read request
// FETCH | waiting on the addressed source's valid, timeout counter running
// RESP  | response held for the TAP until READ_DATA_READY_I
module tap_read_interconnect #(
  parameter int READ_WIDTH        = 41,
  parameter int DMI_WIDTH         = 41,
  parameter int STB_CONTROL_WIDTH = 8,
  parameter int STB_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int IRLENGTH          = 5,
  parameter logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11,
  parameter logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h12,
  parameter logic [IRLENGTH-1:0] ADDR_STB0_D  = 5'h13,
  parameter logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h14,
  parameter logic [IRLENGTH-1:0] ADDR_STB1_D  = 5'h15
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic [IRLENGTH-1:0]          READ_ADDRESS_I,
  input  logic                         READ_VALID_I,
  output logic                         READ_READY_O,
  output logic [READ_WIDTH-1:0]        READ_DATA_O,
  output logic                         READ_ERROR_O,
  output logic                         READ_DATA_VALID_O,
  input  logic                         READ_DATA_READY_I,
  input  logic                         DMI_READ_VALID_I,
  input  logic [DMI_WIDTH-1:0]         DMI_READ_DATA_I,
  output logic                         DMI_READ_READY_O,
  input  logic                         STB0_CONTROL_VALID_I,
  input  logic [STB_CONTROL_WIDTH-1:0] STB0_CONTROL_I,
  output logic                         STB0_CONTROL_READY_O,
  input  logic                         STB0_DATA_VALID_I,
  input  logic [STB_DATA_WIDTH-1:0]    STB0_DATA_I,
  output logic                         STB0_DATA_READY_O,
  input  logic                         STB1_CONTROL_VALID_I,
  input  logic [STB_CONTROL_WIDTH-1:0] STB1_CONTROL_I,
  output logic                         STB1_CONTROL_READY_O,
  input  logic                         STB1_DATA_VALID_I,
  input  logic [STB_DATA_WIDTH-1:0]    STB1_DATA_I,
  output logic                         STB1_DATA_READY_O
);

  // A zero TIMEOUT_CYCLES still needs a 1-bit counter to keep the vector legal.
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t                state_q, state_d;
  logic [IRLENGTH-1:0]   addr_q, addr_d;
  logic [READ_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                  read_ready, fetch_en, addr_known, tmo_expire;
  logic                  sel_dmi, sel_s0c, sel_s0d, sel_s1c, sel_s1d;
  logic                  src_valid;
  logic [READ_WIDTH-1:0] src_data;

  assign addr_known = (READ_ADDRESS_I == ADDR_DMI)     || (READ_ADDRESS_I == ADDR_STB0_CS) ||
                      (READ_ADDRESS_I == ADDR_STB0_D)  || (READ_ADDRESS_I == ADDR_STB1_CS) ||
                      (READ_ADDRESS_I == ADDR_STB1_D);

  assign sel_dmi = (addr_q == ADDR_DMI);
  assign sel_s0c = (addr_q == ADDR_STB0_CS);
  assign sel_s0d = (addr_q == ADDR_STB0_D);
  assign sel_s1c = (addr_q == ADDR_STB1_CS);
  assign sel_s1d = (addr_q == ADDR_STB1_D);

  assign tmo_expire = TMO_EN && (tmo_q == TMO_LAST);

  // Size casts zero-extend narrow sources and keep the LSBs of wide ones.
  always_comb begin
    src_valid = 1'b0;
    src_data  = '0;
    if (sel_dmi) begin
      src_valid = DMI_READ_VALID_I;
      src_data  = READ_WIDTH'(DMI_READ_DATA_I);
    end else if (sel_s0c) begin
      src_valid = STB0_CONTROL_VALID_I;
      src_data  = READ_WIDTH'(STB0_CONTROL_I);
    end else if (sel_s0d) begin
      src_valid = STB0_DATA_VALID_I;
      src_data  = READ_WIDTH'(STB0_DATA_I);
    end else if (sel_s1c) begin
      src_valid = STB1_CONTROL_VALID_I;
      src_data  = READ_WIDTH'(STB1_CONTROL_I);
    end else if (sel_s1d) begin
      src_valid = STB1_DATA_VALID_I;
      src_data  = READ_WIDTH'(STB1_DATA_I);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    read_ready = 1'b0;
    fetch_en   = 1'b0;
    case (state_q)
      IDLE: begin
        read_ready = 1'b1;
        if (READ_VALID_I) begin
          addr_d = READ_ADDRESS_I;
          tmo_d  = '0;
          err_d  = 1'b0;
          if (addr_known) begin
            state_d = FETCH;
          end else begin
            data_d  = '0;
            state_d = RESP;
          end
        end
      end
      FETCH: begin
        fetch_en = 1'b1;
        if (src_valid) begin
          data_d  = src_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_expire) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        if (READ_DATA_READY_I) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs are gated by RST_I so a reset drops every handshake in the same cycle.
  assign READ_READY_O         = read_ready & ~RST_I;
  assign READ_DATA_VALID_O    = (state_q == RESP) & ~RST_I;
  assign READ_DATA_O          = READ_DATA_VALID_O ? data_q : '0;
  assign READ_ERROR_O         = READ_DATA_VALID_O & err_q;
  assign DMI_READ_READY_O     = fetch_en & sel_dmi & ~RST_I;
  assign STB0_CONTROL_READY_O = fetch_en & sel_s0c & ~RST_I;
  assign STB0_DATA_READY_O    = fetch_en & sel_s0d & ~RST_I;
  assign STB1_CONTROL_READY_O = fetch_en & sel_s1c & ~RST_I;
  assign STB1_DATA_READY_O    = fetch_en & sel_s1d & ~RST_I;

endmodule
